// File: rtl/simple_pipelined.sv
// simple_pipelined: LANES x WIDTH elastic delay line of DEPTH valid/ready stages (DEPTH=0 is a wire).
// Optional feature macro PIPE_OCC_EN adds a registered occupancy output occ.

module simple_pipelined_lane #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DEPTH-1:0] ld,
  input  logic [DEPTH-1:0] src_v,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [DEPTH-1:0][WIDTH-1:0] dq;
  logic [DEPTH-1:0][WIDTH-1:0] src_d;

  always_comb begin
    src_d[0] = din;
    for (int k = 1; k < DEPTH; k++) src_d[k] = dq[k-1];
  end

  // A bubble moving in keeps the old data; only the valid bit clears.
  always_ff @(posedge clk) begin
    if (rst) dq <= '0;
    else begin
      for (int k = 0; k < DEPTH; k++)
        if (ld[k] && src_v[k]) dq[k] <= src_d[k];
    end
  end

  assign dout = dq[DEPTH-1];
endmodule

module simple_pipelined #(
  parameter int WIDTH = 16,
  parameter int LANES = 1,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*LANES-1:0] i,
  output logic [WIDTH*LANES-1:0] o,
  output logic                   o_valid,
  input  logic                   out_ready
`ifdef PIPE_OCC_EN
  ,
  output logic [$clog2(DEPTH+2)-1:0] occ
`endif
);
  localparam int OW = $clog2(DEPTH+2);

  generate
    if (DEPTH == 0) begin : g_pass
      assign o        = i;
      assign o_valid  = in_valid;
      assign in_ready = out_ready;
`ifdef PIPE_OCC_EN
      assign occ = '0;
`endif
    end else begin : g_pipe
      logic [DEPTH-1:0] vld_pipe;
      logic [DEPTH-1:0] src_v;
      logic [DEPTH-1:0] ld;
      logic [LANES-1:0][WIDTH-1:0] i_l;
      logic [LANES-1:0][WIDTH-1:0] o_l;

      // Load chain: a stage loads when it is empty or everything downstream moves.
      always_comb begin
        logic acc;
        acc = out_ready;
        for (int k = DEPTH-1; k >= 0; k--) begin
          acc   = acc | ~vld_pipe[k];
          ld[k] = acc;
        end
      end

      always_comb begin
        src_v[0] = in_valid;
        for (int k = 1; k < DEPTH; k++) src_v[k] = vld_pipe[k-1];
      end

      always_ff @(posedge clk) begin
        if (rst) vld_pipe <= '0;
        else begin
          for (int k = 0; k < DEPTH; k++)
            if (ld[k]) vld_pipe[k] <= src_v[k];
        end
      end

      assign in_ready = ld[0];
      assign o_valid  = vld_pipe[DEPTH-1];
      assign i_l      = i;
      assign o        = o_l;

      simple_pipelined_lane #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane [LANES-1:0] (
        .clk   (clk),
        .rst   (rst),
        .ld    (ld),
        .src_v (src_v),
        .din   (i_l),
        .dout  (o_l)
      );

`ifdef PIPE_OCC_EN
      logic xin, xout;
      assign xin  = in_valid & ld[0];
      assign xout = vld_pipe[DEPTH-1] & out_ready;

      always_ff @(posedge clk) begin
        if (rst) occ <= '0;
        else begin
          case ({xin, xout})
            2'b10:   occ <= occ + OW'(1);
            2'b01:   occ <= occ - OW'(1);
            default: occ <= occ;
          endcase
        end
      end
`endif
    end
  endgenerate
endmodule

// File: tb/tb_simple_pipelined.sv
// Directed bench for simple_pipelined: DEPTH 0..4 instances, one 4-lane instance,
// a vector table for the DEPTH=2 flow-control sequence plus hand-written corner sequences.
module tb_simple_pipelined;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic iv0, ir0, ov0, or0; logic [15:0] i0, o0;
  logic iv1, ir1, ov1, or1; logic [31:0] i1, o1;
  logic iv2, ir2, ov2, or2; logic [15:0] i2, o2;
  logic iv3, ir3, ov3, or3; logic [15:0] i3, o3;
  logic iv4, ir4, ov4, or4; logic [15:0] i4, o4;
`ifdef PIPE_OCC_EN
  logic [0:0] occ0; logic [1:0] occ1; logic [1:0] occ2; logic [2:0] occ3; logic [2:0] occ4;
`endif

  simple_pipelined #(.WIDTH(16), .LANES(1), .DEPTH(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .i(i0), .o(o0),
    .o_valid(ov0), .out_ready(or0)
`ifdef PIPE_OCC_EN
    , .occ(occ0)
`endif
  );
  simple_pipelined #(.WIDTH(8), .LANES(4), .DEPTH(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .i(i1), .o(o1),
    .o_valid(ov1), .out_ready(or1)
`ifdef PIPE_OCC_EN
    , .occ(occ1)
`endif
  );
  simple_pipelined #(.WIDTH(16), .LANES(1), .DEPTH(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .i(i2), .o(o2),
    .o_valid(ov2), .out_ready(or2)
`ifdef PIPE_OCC_EN
    , .occ(occ2)
`endif
  );
  simple_pipelined #(.WIDTH(16), .LANES(1), .DEPTH(3)) u3 (
    .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3), .i(i3), .o(o3),
    .o_valid(ov3), .out_ready(or3)
`ifdef PIPE_OCC_EN
    , .occ(occ3)
`endif
  );
  simple_pipelined #(.WIDTH(16), .LANES(1), .DEPTH(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .i(i4), .o(o4),
    .o_valid(ov4), .out_ready(or4)
`ifdef PIPE_OCC_EN
    , .occ(occ4)
`endif
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic next_cyc;
    @(posedge clk); #1;
  endtask

`ifdef PIPE_OCC_EN
  // Occupancy reference: count of words held, tracked from handshakes at each edge.
  int m3 = 0, m4 = 0;
  always @(posedge clk) begin
    if (rst) begin m3 <= 0; m4 <= 0; end
    else begin
      m3 <= m3 + int'(iv3 & ir3) - int'(ov3 & or3);
      m4 <= m4 + int'(iv4 & ir4) - int'(ov4 & or4);
    end
  end
  always @(negedge clk) begin
    if (!rst) begin
      chk("occ3", 32'(occ3), 32'(m3));
      chk("occ4", 32'(occ4), 32'(m4));
    end
  end
`endif

  typedef struct {
    logic        iv;
    logic [15:0] i;
    logic        orr;
    logic        eir;
    logic        eov;
    logic [15:0] eo;
  } vec_t;
  vec_t tbl [13];

  initial begin
    // DEPTH=2: backpressure fill, release with C offered, drain, bubble keeps old data.
    tbl[0]  = '{1'b1, 16'hAAAA, 1'b0, 1'b1, 1'b0, 16'h0000};
    tbl[1]  = '{1'b1, 16'hBBBB, 1'b0, 1'b1, 1'b0, 16'h0000};
    tbl[2]  = '{1'b1, 16'hCCCC, 1'b0, 1'b0, 1'b1, 16'hAAAA};
    tbl[3]  = '{1'b1, 16'hCCCC, 1'b1, 1'b1, 1'b1, 16'hAAAA};
    tbl[4]  = '{1'b0, 16'hDDDD, 1'b1, 1'b1, 1'b1, 16'hBBBB};
    tbl[5]  = '{1'b0, 16'hDDDD, 1'b0, 1'b1, 1'b1, 16'hCCCC};
    tbl[6]  = '{1'b0, 16'hDDDD, 1'b1, 1'b1, 1'b1, 16'hCCCC};
    tbl[7]  = '{1'b0, 16'hDDDD, 1'b1, 1'b1, 1'b0, 16'hCCCC};
    tbl[8]  = '{1'b1, 16'h1111, 1'b1, 1'b1, 1'b0, 16'hCCCC};
    tbl[9]  = '{1'b1, 16'h2222, 1'b1, 1'b1, 1'b0, 16'hCCCC};
    tbl[10] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h1111};
    tbl[11] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h2222};
    tbl[12] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h2222};

    {iv0, or0, iv1, or1, iv2, or2, iv4, or4} = '0;
    i0 = '0; i1 = '0; i2 = '0; i4 = '0;
    iv3 = 1'b1; i3 = 16'hBEEF; or3 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; iv3 = 1'b0;
    @(negedge clk);
    chk("reset d3 o_valid", 32'(ov3), 32'd0);
    chk("reset d3 o", 32'(o3), 32'd0);
    chk("reset d2 o_valid", 32'(ov2), 32'd0);
    next_cyc();

    for (int c = 0; c < 13; c++) begin
      iv2 = tbl[c].iv; i2 = tbl[c].i; or2 = tbl[c].orr;
      @(negedge clk);
      chk($sformatf("d2 c%0d in_ready", c), 32'(ir2), 32'(tbl[c].eir));
      chk($sformatf("d2 c%0d o_valid", c), 32'(ov2), 32'(tbl[c].eov));
      chk($sformatf("d2 c%0d o", c), 32'(o2), 32'(tbl[c].eo));
      next_cyc();
    end
    iv2 = 1'b0; or2 = 1'b0;

    // DEPTH=3 latency: 1..6 streamed, first out 3 edges after first accept, no gaps.
    or3 = 1'b1;
    for (int c = 0; c < 10; c++) begin
      iv3 = (c < 6); i3 = 16'(c + 1);
      @(negedge clk);
      chk($sformatf("d3 lat c%0d o_valid", c), 32'(ov3), 32'(c >= 3 && c < 9));
      if (c >= 3 && c < 9) chk($sformatf("d3 lat c%0d o", c), 32'(o3), 32'(c - 2));
      next_cyc();
    end

    // DEPTH=3 fill with out_ready=0, then reset mid-flight.
    or3 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      iv3 = 1'b1; i3 = 16'(7 + c);
      @(negedge clk);
      chk($sformatf("d3 fill c%0d in_ready", c), 32'(ir3), 32'd1);
      next_cyc();
    end
    rst = 1'b1; i3 = 16'hBEEF;
    @(negedge clk);
    chk("d3 rst0 in_ready", 32'(ir3), 32'd0);
    chk("d3 rst0 o", 32'(o3), 32'd7);
    next_cyc();
    @(negedge clk);
    chk("d3 rst1 in_ready", 32'(ir3), 32'd1);
    chk("d3 rst1 o_valid", 32'(ov3), 32'd0);
    next_cyc();
    rst = 1'b0; iv3 = 1'b0;
    @(negedge clk);
    chk("d3 post rst o_valid", 32'(ov3), 32'd0);
    chk("d3 post rst o", 32'(o3), 32'd0);
    next_cyc();
    @(negedge clk);
    chk("d3 post rst2 o_valid", 32'(ov3), 32'd0);
    next_cyc();

    // DEPTH=4 bubble collapse: X packs to the output stage, then Y,Z,W fill behind it.
    or4 = 1'b0; iv4 = 1'b1; i4 = 16'h00A0;
    next_cyc();
    iv4 = 1'b0;
    for (int c = 1; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("d4 c%0d o_valid", c), 32'(ov4), 32'd0);
      chk($sformatf("d4 c%0d in_ready", c), 32'(ir4), 32'd1);
      next_cyc();
    end
    for (int c = 4; c < 7; c++) begin
      iv4 = 1'b1; i4 = 16'(16'h00A0 + c - 3);
      @(negedge clk);
      chk($sformatf("d4 c%0d in_ready", c), 32'(ir4), 32'd1);
      chk($sformatf("d4 c%0d o", c), 32'(o4), 32'h00A0);
      chk($sformatf("d4 c%0d o_valid", c), 32'(ov4), 32'd1);
      next_cyc();
    end
    i4 = 16'h0BAD;
    @(negedge clk);
    chk("d4 full in_ready", 32'(ir4), 32'd0);
    chk("d4 full o", 32'(o4), 32'h00A0);
    next_cyc();
    iv4 = 1'b0; or4 = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("d4 drain%0d o_valid", c), 32'(ov4), 32'(c < 4));
      if (c < 4) chk($sformatf("d4 drain%0d o", c), 32'(o4), 32'(16'h00A0 + c));
      next_cyc();
    end
    or4 = 1'b0;

    // 4 lanes x 8 bits, DEPTH=1.
    iv1 = 1'b1; i1 = 32'h04030201; or1 = 1'b1;
    @(negedge clk);
    chk("ml c0 in_ready", 32'(ir1), 32'd1);
    chk("ml c0 o_valid", 32'(ov1), 32'd0);
    next_cyc();
    i1 = 32'hA1B2C3D4; or1 = 1'b0;
    @(negedge clk);
    chk("ml c1 o", o1, 32'h04030201);
    chk("ml c1 o_valid", 32'(ov1), 32'd1);
    chk("ml c1 in_ready", 32'(ir1), 32'd0);
    next_cyc();
    or1 = 1'b1;
    @(negedge clk);
    chk("ml c2 o", o1, 32'h04030201);
    chk("ml c2 in_ready", 32'(ir1), 32'd1);
    next_cyc();
    iv1 = 1'b0;
    @(negedge clk);
    chk("ml c3 o", o1, 32'hA1B2C3D4);
    next_cyc();
    @(negedge clk);
    chk("ml c4 o_valid", 32'(ov1), 32'd0);
    next_cyc();

    // DEPTH=0 combinational passthrough.
    iv0 = 1'b1; i0 = 16'h1234; or0 = 1'b0;
    #1;
    chk("d0 o", 32'(o0), 32'h1234);
    chk("d0 o_valid", 32'(ov0), 32'd1);
    chk("d0 in_ready", 32'(ir0), 32'd0);
    or0 = 1'b1; iv0 = 1'b0;
    #1;
    chk("d0 in_ready hi", 32'(ir0), 32'd1);
    chk("d0 o_valid lo", 32'(ov0), 32'd0);

    next_cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
